flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Sits directly downstream of the ALU and upstream of the PC.
- Registers the ALU's comparison and carry flags, and evaluates the conditional branch for the instruction in decode. The carry flag is fed back to the ALU's carry input.
- Computes the next jump target, either PC-relative or from a small programmable jump LUT, and presents it to the PC.
- Holds the front end for a fixed number of flush cycles after a taken branch.

Parameters:
- PC_W, 12, program counter / target width
- LUT_DEPTH, 8, number of jump LUT entries (power of two)
- FLUSH_CYCLES, 2, bubble cycles asserted after a taken branch (must be ≥1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- flag_we  in  1  latch ALU flags this cycle (flag-setting op retiring)
- equal, gt, lt, zero, c_o  in  1 each  combinational flags from ALU
- br_valid  in  1  decoded branch present this cycle
- br_cond  in  3  condition code (encoding below)
- br_use_lut  in  1  1: target from LUT, 0: PC-relative
- br_imm  in  8  signed offset, or LUT index in low log2(LUT_DEPTH) bits
- prog_ctr  in  PC_W  PC of the branch instruction
- lut_we  in  1  write jump LUT
- lut_waddr  in  log2(LUT_DEPTH)  LUT write index
- lut_wdata  in  PC_W  LUT write data
- equalQ, gtQ, ltQ, zeroQ  out  1 each  registered flags
- c_i  out  1  registered carry, drives ALU carry-in
- taken  out  1  one-cycle pulse: PC must load target
- target  out  PC_W  jump target, valid while taken=1
- flush  out  1  squash fetch/decode; upstream must not assert br_valid/flag_we for squashed instrs

Behaviour:
- Reset (reset=0, async):
  - All flags, c_i, taken and flush are 0; target is 0; FSM goes to IDLE; all LUT entries are 0.
  - Takes effect immediately, including mid-flush.
- Flag register:
  - When flag_we=1 and state is IDLE, the five flags load from the ALU inputs at the clock edge.
  - Otherwise they hold.
  - flag_we in FLUSH is ignored.
- Condition codes:
  - 000 always; 001 equalQ; 010 !equalQ; 011 gtQ; 100 ltQ; 101 zeroQ; 110 c_i; 111 never.
  - Conditions use the registered flags. A flag_we and br_valid in the same cycle: the branch sees the OLD flags and the flags update at that edge.
- Target:
  - br_use_lut=0: target = prog_ctr + sign_extend(br_imm), modulo 2^PC_W. Wrap-around is legal, e.g. 0x000 + (-1) = 0xFFF.
  - br_use_lut=1: target = lut[br_imm[log2(LUT_DEPTH)-1:0]]. Upper imm bits are ignored.
  - A LUT write and a LUT read of the same index in the same cycle: the read returns the OLD entry.
  - LUT writes are accepted in every state.
- FSM, states IDLE and FLUSH:
  - IDLE, br_valid=1 and condition true:
    - Next edge: taken=1, target registered, flush=1.
    - Flush counter loads FLUSH_CYCLES-1; go to FLUSH.
  - IDLE, br_valid=1 and condition false: taken stays 0, target holds its previous value, stay in IDLE.
  - FLUSH:
    - taken=0, flush=1.
    - Counter decrements each cycle. When it is 0 at a clock edge, flush drops at that edge and the FSM returns to IDLE.
    - br_valid and flag_we are ignored.
- Timing:
  - Latency from br_valid to taken is 1 cycle.
  - taken is never high for 2 consecutive cycles.
  - flush is high for exactly FLUSH_CYCLES cycles, starting the same cycle as taken.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle:
  - Assert reset=0 mid-cycle while taken=1 / flush=1 → all outputs are 0 immediately.
  - After release, the FSM is IDLE and a LUT read returns 0.
- Flag latch and conditional branch:
  - equal=1, flag_we=1, then br_valid with cond=001, prog_ctr=0x257, imm=0x04 → one cycle later taken=1, target=0x25B, flush high 2 cycles.
  - Same sequence with cond=010 → taken stays 0.
- Same-cycle hazard:
  - equalQ=0, then flag_we=1 with equal=1 and br_valid cond=001 in the same cycle → not taken, equalQ=1 afterwards.
- Wrap-around:
  - prog_ctr=0x000, imm=0xFF (-1) → target=0xFFF.
  - prog_ctr=0xFFF, imm=0x01 → target=0x000.
- LUT:
  - Write lut[3]=0xABC, then br_use_lut=1, imm=0x0B, cond=000 → target=0xABC.
  - Simultaneous write of lut[3]=0x123 with the branch → target=0xABC (old value).
- Flush suppression and carry:
  - During FLUSH, br_valid cond=000 and flag_we with c_o=1 → no second taken, c_i unchanged.
  - After return to IDLE, flag_we with c_o=1 → c_i=1; then a branch with cond=110 → taken.

Source files
------------

// File: rtl/flag_branch_unit.sv
// Flag register, conditional branch evaluation and jump target generation
// between the ALU and the PC, with a fixed-length front-end flush after taken branches.
module flag_branch_unit #(
  parameter int PC_W         = 12,
  parameter int LUT_DEPTH    = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flag_we,
  input  logic                         equal,
  input  logic                         gt,
  input  logic                         lt,
  input  logic                         zero,
  input  logic                         c_o,
  input  logic                         br_valid,
  input  logic [2:0]                   br_cond,
  input  logic                         br_use_lut,
  input  logic [7:0]                   br_imm,
  input  logic [PC_W-1:0]              prog_ctr,
  input  logic                         lut_we,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
  input  logic [PC_W-1:0]              lut_wdata,
  output logic                         equalQ,
  output logic                         gtQ,
  output logic                         ltQ,
  output logic                         zeroQ,
  output logic                         c_i,
  output logic                         taken,
  output logic [PC_W-1:0]              target,
  output logic                         flush
);

  localparam int IDX_W = $clog2(LUT_DEPTH);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic [PC_W-1:0]  lut [LUT_DEPTH];
  logic             cond_true;
  logic [PC_W-1:0]  imm_ext;
  logic [PC_W-1:0]  next_target;

  // Branch conditions look only at the registered flags, so a same-cycle flag write is not seen.
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = equalQ;
      3'b010:  cond_true = ~equalQ;
      3'b011:  cond_true = gtQ;
      3'b100:  cond_true = ltQ;
      3'b101:  cond_true = zeroQ;
      3'b110:  cond_true = c_i;
      default: cond_true = 1'b0;
    endcase
  end

  assign imm_ext     = {{(PC_W-8){br_imm[7]}}, br_imm};
  assign next_target = br_use_lut ? lut[br_imm[IDX_W-1:0]] : prog_ctr + imm_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
      equalQ    <= 1'b0;
      gtQ       <= 1'b0;
      ltQ       <= 1'b0;
      zeroQ     <= 1'b0;
      c_i       <= 1'b0;
      taken     <= 1'b0;
      target    <= '0;
      flush     <= 1'b0;
    end else begin
      taken <= 1'b0;
      case (state)
        IDLE: begin
          if (flag_we) begin
            equalQ <= equal;
            gtQ    <= gt;
            ltQ    <= lt;
            zeroQ  <= zero;
            c_i    <= c_o;
          end
          if (br_valid && cond_true) begin
            taken     <= 1'b1;
            target    <= next_target;
            flush     <= 1'b1;
            flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: a cycle-level reference model checked every cycle,
// plus literal expectations taken from hand-worked branch scenarios.
module tb_flag_branch_unit;

  localparam int PC_W = 12;
  localparam int LUT_DEPTH = 8;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flag_we, equal, gt, lt, zero, c_o;
  logic        br_valid, br_use_lut, lut_we;
  logic [2:0]  br_cond;
  logic [7:0]  br_imm;
  logic [11:0] prog_ctr, lut_wdata, target;
  logic [2:0]  lut_waddr;
  logic        equalQ, gtQ, ltQ, zeroQ, c_i, taken, flush;

  int errors = 0;
  int checks = 0;

  flag_branch_unit #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .reset(reset), .flag_we(flag_we), .equal(equal), .gt(gt), .lt(lt),
    .zero(zero), .c_o(c_o), .br_valid(br_valid), .br_cond(br_cond), .br_use_lut(br_use_lut),
    .br_imm(br_imm), .prog_ctr(prog_ctr), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .equalQ(equalQ), .gtQ(gtQ), .ltQ(ltQ), .zeroQ(zeroQ), .c_i(c_i),
    .taken(taken), .target(target), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: flags as plain bits, flush tracked as "cycles of bubble still to show".
  bit          m_flag [5];
  bit          m_taken;
  logic [11:0] m_target;
  int          flush_left;
  logic [11:0] m_lut [LUT_DEPTH];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) m_flag[i] = 0;
      for (int i = 0; i < LUT_DEPTH; i++) m_lut[i] = '0;
      m_taken = 0;
      m_target = '0;
      flush_left = 0;
    end else begin
      bit go;
      int t;
      case (br_cond)
        3'd0: go = 1;
        3'd1: go = m_flag[0];
        3'd2: go = !m_flag[0];
        3'd3: go = m_flag[1];
        3'd4: go = m_flag[2];
        3'd5: go = m_flag[3];
        3'd6: go = m_flag[4];
        default: go = 0;
      endcase
      m_taken = 0;
      if (flush_left == 0) begin
        if (br_valid && go) begin
          m_taken = 1;
          t = int'(prog_ctr) + int'($signed(br_imm));
          m_target = br_use_lut ? m_lut[br_imm % LUT_DEPTH] : t[11:0];
          flush_left = FLUSH_CYCLES;
        end
        if (flag_we) begin
          m_flag[0] = equal; m_flag[1] = gt; m_flag[2] = lt;
          m_flag[3] = zero;  m_flag[4] = c_o;
        end
      end else begin
        flush_left = flush_left - 1;
      end
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset) begin
      checkOutput("model_taken", 32'(taken), 32'(m_taken));
      checkOutput("model_flush", 32'(flush), 32'(flush_left > 0));
      checkOutput("model_target", 32'(target), 32'(m_target));
      checkOutput("model_equalQ", 32'(equalQ), 32'(m_flag[0]));
      checkOutput("model_gtQ", 32'(gtQ), 32'(m_flag[1]));
      checkOutput("model_ltQ", 32'(ltQ), 32'(m_flag[2]));
      checkOutput("model_zeroQ", 32'(zeroQ), 32'(m_flag[3]));
      checkOutput("model_c_i", 32'(c_i), 32'(m_flag[4]));
    end
  end

  task automatic clearInputs();
    flag_we = 0; equal = 0; gt = 0; lt = 0; zero = 0; c_o = 0;
    br_valid = 0; br_cond = 3'd0; br_use_lut = 0; br_imm = 8'h00; prog_ctr = 12'h000;
    lut_we = 0; lut_waddr = 3'd0; lut_wdata = 12'h000;
  endtask

  // Holds the currently set inputs across one rising edge, then returns them to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
    clearInputs();
  endtask

  task automatic setBranch(input logic [2:0] cond, input logic use_lut,
                           input logic [7:0] imm, input logic [11:0] pc);
    br_valid = 1; br_cond = cond; br_use_lut = use_lut; br_imm = imm; prog_ctr = pc;
  endtask

  initial begin
    clearInputs();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_taken", 32'(taken), 32'd0);
    checkOutput("reset_flush", 32'(flush), 32'd0);
    checkOutput("reset_target", 32'(target), 32'd0);
    reset = 1;
    applyStimulus();

    // Flag latch then taken branch on equalQ
    flag_we = 1; equal = 1;
    applyStimulus();
    checkOutput("eq_latched", 32'(equalQ), 32'd1);
    setBranch(3'b001, 0, 8'h04, 12'h257);
    applyStimulus();
    checkOutput("beq_taken", 32'(taken), 32'd1);
    checkOutput("beq_target", 32'(target), 32'h25B);
    checkOutput("beq_flush0", 32'(flush), 32'd1);
    applyStimulus();
    checkOutput("beq_taken_pulse", 32'(taken), 32'd0);
    checkOutput("beq_flush1", 32'(flush), 32'd1);
    applyStimulus();
    checkOutput("beq_flush_end", 32'(flush), 32'd0);

    // Inverse condition must not branch, target holds
    setBranch(3'b010, 0, 8'h04, 12'h300);
    applyStimulus();
    checkOutput("bne_not_taken", 32'(taken), 32'd0);
    checkOutput("bne_target_hold", 32'(target), 32'h25B);

    // Same-cycle flag write and branch sees old flags
    flag_we = 1; equal = 0;
    applyStimulus();
    flag_we = 1; equal = 1;
    setBranch(3'b001, 0, 8'h10, 12'h040);
    applyStimulus();
    checkOutput("hazard_not_taken", 32'(taken), 32'd0);
    checkOutput("hazard_eq_new", 32'(equalQ), 32'd1);

    // PC-relative wrap-around in both directions
    setBranch(3'b000, 0, 8'hFF, 12'h000);
    applyStimulus();
    checkOutput("wrap_down", 32'(target), 32'hFFF);
    repeat (2) applyStimulus();
    setBranch(3'b000, 0, 8'h01, 12'hFFF);
    applyStimulus();
    checkOutput("wrap_up", 32'(target), 32'h000);
    repeat (2) applyStimulus();

    // LUT targets, including read-before-write on the same index
    lut_we = 1; lut_waddr = 3'd3; lut_wdata = 12'hABC;
    applyStimulus();
    setBranch(3'b000, 1, 8'h0B, 12'h555);
    applyStimulus();
    checkOutput("lut_target", 32'(target), 32'hABC);
    repeat (2) applyStimulus();
    setBranch(3'b000, 1, 8'h03, 12'h555);
    lut_we = 1; lut_waddr = 3'd3; lut_wdata = 12'h123;
    applyStimulus();
    checkOutput("lut_old_value", 32'(target), 32'hABC);
    repeat (2) applyStimulus();
    setBranch(3'b000, 1, 8'hF3, 12'h555);
    applyStimulus();
    checkOutput("lut_new_value", 32'(target), 32'h123);
    repeat (2) applyStimulus();

    // Branches and flag writes during flush are dropped
    setBranch(3'b000, 0, 8'h10, 12'h100);
    applyStimulus();
    checkOutput("flush_br_taken", 32'(taken), 32'd1);
    repeat (2) begin
      setBranch(3'b000, 0, 8'h20, 12'h200);
      flag_we = 1; c_o = 1;
      applyStimulus();
      checkOutput("flush_no_taken", 32'(taken), 32'd0);
      checkOutput("flush_ci_hold", 32'(c_i), 32'd0);
    end
    checkOutput("flush_done", 32'(flush), 32'd0);
    checkOutput("flush_target_hold", 32'(target), 32'h110);
    flag_we = 1; c_o = 1;
    applyStimulus();
    checkOutput("carry_latched", 32'(c_i), 32'd1);
    setBranch(3'b110, 0, 8'h80, 12'h100);
    applyStimulus();
    checkOutput("bcs_taken", 32'(taken), 32'd1);
    checkOutput("bcs_target", 32'(target), 32'h080);
    repeat (2) applyStimulus();

    // Asynchronous reset in the middle of a taken/flush window
    setBranch(3'b000, 0, 8'h05, 12'h010);
    @(posedge clk);
    #3;
    clearInputs();
    checkOutput("pre_reset_taken", 32'(taken), 32'd1);
    reset = 0;
    #1;
    checkOutput("async_taken", 32'(taken), 32'd0);
    checkOutput("async_flush", 32'(flush), 32'd0);
    checkOutput("async_target", 32'(target), 32'd0);
    checkOutput("async_flags", 32'({equalQ, gtQ, ltQ, zeroQ, c_i}), 32'd0);
    @(negedge clk);
    reset = 1;
    setBranch(3'b000, 1, 8'h03, 12'h777);
    applyStimulus();
    checkOutput("post_reset_taken", 32'(taken), 32'd1);
    checkOutput("post_reset_lut", 32'(target), 32'h000);
    repeat (3) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
